// File: rtl/regfile_param.sv
// Parametrised register file with hardwired-zero x0 and a one-entry-per-cycle clear sequencer.
// Optional same-cycle write-to-read forwarding when REGFILE_BYPASS_EN is defined.
module regfile_param #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREGS = 32,
  parameter int unsigned AW    = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   A1,
  input  logic [AW-1:0]   A2,
  input  logic [AW-1:0]   A3,
  input  logic [XLEN-1:0] WD3,
  input  logic            WE3,
  input  logic            clr_req,
  output logic [XLEN-1:0] RD1,
  output logic [XLEN-1:0] RD2,
  output logic            ready,
  output logic            wr_drop
);

  localparam logic [0:0] S_CLEAR = 1'b0;
  localparam logic [0:0] S_READY = 1'b1;

  // Elaboration-time parameter sanity
  generate
    if (XLEN < 8) begin : g_bad_xlen
      $error("regfile_param: XLEN must be >= 8");
    end
    if ((NREGS < 4) || ((NREGS & (NREGS - 1)) != 0)) begin : g_bad_nregs
      $error("regfile_param: NREGS must be a power of two >= 4");
    end
    if (AW != $clog2(NREGS)) begin : g_bad_aw
      $error("regfile_param: AW must equal clog2(NREGS)");
    end
  endgenerate

  logic [0:0]      state, state_next;
  logic [AW-1:0]   clr_idx, clr_idx_next;
  logic            ready_next;
  logic            wr_drop_next;
  logic            mem_we;
  logic [AW-1:0]   mem_addr;
  logic [XLEN-1:0] mem_data;
  logic [XLEN-1:0] mem [NREGS];
  logic            wr_live;

  // State, sequencer index and flag registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_CLEAR;
      clr_idx <= '0;
      ready   <= 1'b0;
      wr_drop <= 1'b0;
    end else begin
      state   <= state_next;
      clr_idx <= clr_idx_next;
      ready   <= ready_next;
      wr_drop <= wr_drop_next;
    end
  end

  // Next state; the single array write port is shared by the clear sequencer and the core
  always_comb begin
    state_next   = state;
    clr_idx_next = clr_idx;
    ready_next   = ready;
    wr_drop_next = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = A3;
    mem_data     = WD3;
    case (state)
      S_CLEAR: begin
        mem_we       = 1'b1;
        mem_addr     = clr_idx;
        mem_data     = '0;
        clr_idx_next = clr_idx + AW'(1);
        wr_drop_next = WE3;
        if (clr_idx == AW'(NREGS - 1)) begin
          state_next = S_READY;
          ready_next = 1'b1;
        end
      end
      S_READY: begin
        mem_we = WE3 && (A3 != '0);
        if (clr_req) begin
          state_next   = S_CLEAR;
          ready_next   = 1'b0;
          clr_idx_next = '0;
        end
      end
      default: begin
        state_next   = S_CLEAR;
        clr_idx_next = '0;
        ready_next   = 1'b0;
      end
    endcase
  end

  // Storage has no reset; the sequencer zeroes it after every reset or clear request
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr] <= mem_data;
    end
  end

  assign wr_live = ready && WE3 && (A3 != '0);

  // Read ports: masked to zero until cleared and for x0
  always_comb begin
    RD1 = '0;
    RD2 = '0;
    if (ready && (A1 != '0)) begin
`ifdef REGFILE_BYPASS_EN
      RD1 = (wr_live && (A3 == A1)) ? WD3 : mem[A1];
`else
      RD1 = mem[A1];
`endif
    end
    if (ready && (A2 != '0)) begin
`ifdef REGFILE_BYPASS_EN
      RD2 = (wr_live && (A3 == A2)) ? WD3 : mem[A2];
`else
      RD2 = mem[A2];
`endif
    end
  end

`ifndef REGFILE_BYPASS_EN
  logic unused_wr_live;
  assign unused_wr_live = wr_live;
`endif

endmodule

// File: tb/tb_regfile_param.sv
// Scoreboard bench for regfile_param: stimulus queues expected values, a negedge monitor checks them.
module tb_regfile_param;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned NREGS = 32;
  localparam int unsigned AW    = 5;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic [AW-1:0]   a1, a2, a3;
  logic [XLEN-1:0] wd3;
  logic            we3, clr_req;
  logic [XLEN-1:0] rd1, rd2;
  logic            ready, wr_drop;

  regfile_param #(.XLEN(XLEN), .NREGS(NREGS)) dut (
    .clk(clk), .rst(rst), .A1(a1), .A2(a2), .A3(a3), .WD3(wd3), .WE3(we3),
    .clr_req(clr_req), .RD1(rd1), .RD2(rd2), .ready(ready), .wr_drop(wr_drop)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          sel;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   done    = 1'b0;

  function automatic void chk(input int sel, input logic [31:0] v, input string nm);
    exp_t e;
    e.sel = sel; e.val = v; e.name = nm;
    q.push_back(e);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: outputs are combinational/settled by the falling edge
  initial begin : monitor
    exp_t        e;
    logic [31:0] act;
    while (!done) begin
      @(negedge clk);
      while (q.size() > 0) begin
        e = q.pop_front();
        case (e.sel)
          0:       act = rd1;
          1:       act = rd2;
          2:       act = {31'b0, ready};
          default: act = {31'b0, wr_drop};
        endcase
        n_tests++;
        if (act !== e.val) begin
          n_fail++;
          $display("FAIL %s: got %h, want %h", e.name, act, e.val);
        end
      end
    end
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL queue_drain: got %0d pending, want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "timeout");
  end

  task automatic write_reg(input logic [AW-1:0] addr, input logic [31:0] data);
    we3 = 1'b1; a3 = addr; wd3 = data;
    tick();
    we3 = 1'b0;
  endtask

  // Count a full clear of n edges: ready low and reads masked, then ready high
  task automatic clear_wait(input int n, input string tag);
    for (int k = 0; k < n; k++) begin
      a1 = 5'd5; a2 = 5'd6;
      chk(2, 0, {tag, "_ready_lo"});
      chk(0, 0, {tag, "_rd1_masked"});
      tick();
    end
    chk(2, 1, {tag, "_ready_hi"});
  endtask

  initial begin : stim
    rst = 1'b1; a1 = '0; a2 = '0; a3 = '0; wd3 = '0; we3 = 1'b0; clr_req = 1'b0;
    tick();
    chk(2, 0, "reset_ready");
    chk(3, 0, "reset_wr_drop");
    tick();
    rst = 1'b0;

    // Reset release: ready low for 32 edges, all reads zero
    for (int k = 0; k < 32; k++) begin
      a1 = AW'(k); a2 = AW'(31 - k);
      chk(2, 0, "rel_ready_lo");
      chk(0, 0, "rel_rd1");
      chk(1, 0, "rel_rd2");
      tick();
    end
    chk(2, 1, "rel_ready_hi");
    for (int i = 0; i < 32; i++) begin
      a1 = AW'(i); a2 = AW'(31 - i);
      chk(0, 0, "init_rd1_zero");
      chk(1, 0, "init_rd2_zero");
      tick();
    end

    // Basic write/read
    a1 = '0;
    write_reg(5'd5, 32'h0000_0006);
    write_reg(5'd6, 32'h0000_000A);
    a1 = 5'd5; a2 = 5'd6;
    chk(0, 32'h6, "wr_rd1_r5");
    chk(1, 32'hA, "wr_rd2_r6");
    chk(3, 0, "wr_no_drop");
    tick();
    a1 = 5'd6; a2 = 5'd6;
    chk(0, 32'hA, "same_addr_rd1");
    chk(1, 32'hA, "same_addr_rd2");
    tick();

    // x0 hardwired to zero, never forwarded
    we3 = 1'b1; a3 = '0; wd3 = 32'hFFFF_FFFF; a1 = '0; a2 = 5'd5;
    chk(0, 0, "x0_same_cycle");
    chk(1, 32'h6, "x0_other_port");
    tick();
    we3 = 1'b0;
    chk(0, 0, "x0_after");
    chk(3, 0, "x0_no_drop");
    tick();

    // Same-cycle read of a write in progress
    we3 = 1'b1; a3 = 5'd9; wd3 = 32'h0000_CAFE; a1 = 5'd9; a2 = '0;
    chk(0, BYP ? 32'h0000_CAFE : 32'h0, "bypass_rd1");
    chk(1, 0, "bypass_rd2_x0");
    tick();
    we3 = 1'b0;
    chk(0, 32'h0000_CAFE, "bypass_after_edge");
    tick();

    // Soft clear with a simultaneous write, plus a write dropped mid-clear
    clr_req = 1'b1; we3 = 1'b1; a3 = 5'd7; wd3 = 32'h55; a1 = 5'd7;
    chk(0, BYP ? 32'h55 : 32'h0, "clr_sim_write_rd");
    tick();
    clr_req = 1'b0; we3 = 1'b0;
    for (int k = 0; k < 32; k++) begin
      a1 = 5'd5;
      we3 = 1'b0;
      if (k == 2) begin
        we3 = 1'b1; a3 = 5'd7; wd3 = 32'h1234;
      end
      chk(2, 0, "sclr_ready_lo");
      chk(0, 0, "sclr_rd1_masked");
      chk(3, (k == 3) ? 32'h1 : 32'h0, "sclr_wr_drop");
      tick();
    end
    we3 = 1'b0;
    chk(2, 1, "sclr_ready_hi");
    chk(3, 0, "sclr_wr_drop_end");
    a1 = 5'd5; a2 = 5'd6;
    chk(0, 0, "sclr_r5_zero");
    chk(1, 0, "sclr_r6_zero");
    tick();
    a1 = 5'd7; a2 = 5'd9;
    chk(0, 0, "sclr_r7_zero");
    chk(1, 0, "sclr_r9_zero");
    tick();

    // Reload, clear, and reassert rst at edge 10 of the clear
    write_reg(5'd5, 32'h6);
    write_reg(5'd6, 32'hA);
    a1 = 5'd5; a2 = 5'd6;
    chk(0, 32'h6, "reload_r5");
    chk(1, 32'hA, "reload_r6");
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    for (int k = 0; k < 10; k++) begin
      chk(2, 0, "rclr_ready_lo");
      tick();
    end
    rst = 1'b1;
    chk(2, 0, "rclr_in_reset");
    tick();
    rst = 1'b0;
    clear_wait(32, "rclr");
    a1 = 5'd5; a2 = 5'd6;
    chk(0, 0, "rclr_r5_zero");
    chk(1, 0, "rclr_r6_zero");
    tick();

    done = 1'b1;
  end

endmodule
